// File: rtl/epp_pkg.sv
// Shared constants for the EPP register block: register map, address-valid mask,
// arbiter state encoding and the address-decode helper.
package epp_pkg;

  localparam int DATA_W    = 8;
  localparam int NUM_STORE = 14;

  localparam logic [7:0] ADDR_CFG0       = 8'h00;
  localparam logic [7:0] ADDR_CFG1       = 8'h01;
  localparam logic [7:0] ADDR_STATUS     = 8'h0E;
  localparam logic [7:0] ADDR_CMD        = 8'h0F;
  localparam logic [7:0] ADDR_VALID_MASK = 8'hF0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOST = 2'd1;
  localparam logic [1:0] ST_APP  = 2'd2;

  function automatic logic addr_valid(input logic [7:0] a);
    return (a & ADDR_VALID_MASK) == 8'h00;
  endfunction

endpackage

// File: rtl/epp_sync_edge.sv
// Two-flop synchronizer with falling-edge detect. Flops reset high so reset
// release never fabricates an edge from the reset value alone.
module epp_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic level,
  output logic fall,
  output logic settled
);

  logic       s1;
  logic       s2;
  logic       prev;
  logic [1:0] settle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= 1'b1;
      s2     <= 1'b1;
      prev   <= 1'b1;
      settle <= 2'b00;
    end else begin
      s1     <= async_in;
      s2     <= s1;
      prev   <= s2;
      settle <= {settle[0], 1'b1};
    end
  end

  // settled goes high once s2 reflects a real sample rather than its reset value
  assign level   = s2;
  assign fall    = prev & ~s2;
  assign settled = settle[1];

endmodule

// File: rtl/epp_reg_arbiter.sv
// EPP host / application register file with a fair two-way arbiter.
// Host strobes are synchronized, latched in a one-deep pending slot and served by the FSM.
module epp_reg_arbiter
  import epp_pkg::*;
#(
  parameter int CLK_MIN_MHZ = 25
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stb_data,
  input  logic              ctrl_wr,
  input  logic [7:0]        bus_addr,
  input  logic [DATA_W-1:0] bus_out,
  output logic [DATA_W-1:0] bus_in,
  input  logic              app_req,
  input  logic              app_wr,
  input  logic [7:0]        app_addr,
  input  logic [DATA_W-1:0] app_wdata,
  output logic              app_ack,
  output logic [DATA_W-1:0] app_rdata,
  input  logic [DATA_W-1:0] status_in,
  output logic [DATA_W-1:0] cfg0,
  output logic [DATA_W-1:0] cfg1,
  output logic              cmd_stb,
  output logic [DATA_W-1:0] cmd_code
);

  if (CLK_MIN_MHZ <= 0) begin : g_clk_check
    $error("CLK_MIN_MHZ must be positive");
  end

  logic              stb_level;
  logic              stb_fall;
  logic              stb_settled;
  logic              ctrl_s1;
  logic              ctrl_s2;
  logic              armed;
  logic              host_edge;

  logic              pend_vld;
  logic              pend_rd;
  logic [7:0]        pend_addr;
  logic [DATA_W-1:0] pend_data;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              last_app;
  logic              app_go;

  logic              acc_en;
  logic              acc_wr;
  logic [7:0]        acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              store_hit;

  logic [DATA_W-1:0] regs [0:NUM_STORE-1];

  epp_sync_edge u_stb_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (stb_data),
    .level    (stb_level),
    .fall     (stb_fall),
    .settled  (stb_settled)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_s1 <= 1'b1;
      ctrl_s2 <= 1'b1;
      armed   <= 1'b0;
    end else begin
      ctrl_s1 <= ctrl_wr;
      ctrl_s2 <= ctrl_s1;
      armed   <= armed | (stb_level & stb_settled);
    end
  end

  assign host_edge = stb_fall & armed;

  // A newer strobe overwrites the slot even if it is still full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld  <= 1'b0;
      pend_rd   <= 1'b0;
      pend_addr <= '0;
      pend_data <= '0;
    end else if (host_edge) begin
      pend_vld  <= 1'b1;
      pend_rd   <= ctrl_s2;
      pend_addr <= bus_addr;
      pend_data <= bus_out;
    end else if (state == ST_HOST) begin
      pend_vld  <= 1'b0;
    end
  end

  // The cycle showing app_ack is not a fresh request; a level held past it is
  assign app_go = app_req & ~app_ack;

  always_comb begin
    state_nxt = ST_IDLE;
    if (state == ST_IDLE) begin
      if (pend_vld && app_go) state_nxt = last_app ? ST_HOST : ST_APP;
      else if (pend_vld)      state_nxt = ST_HOST;
      else if (app_go)        state_nxt = ST_APP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      last_app <= 1'b1;
    end else begin
      state <= state_nxt;
      if (state_nxt == ST_HOST) last_app <= 1'b0;
      else if (state_nxt == ST_APP) last_app <= 1'b1;
    end
  end

  always_comb begin
    acc_en    = 1'b0;
    acc_wr    = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    if (state == ST_HOST) begin
      acc_en    = 1'b1;
      acc_wr    = ~pend_rd;
      acc_addr  = pend_addr;
      acc_wdata = pend_data;
    end else if (state == ST_APP) begin
      acc_en    = 1'b1;
      acc_wr    = app_wr;
      acc_addr  = app_addr;
      acc_wdata = app_wdata;
    end
  end

  assign store_hit = addr_valid(acc_addr) && (acc_addr[3:0] < ADDR_STATUS[3:0]);

  function automatic logic [DATA_W-1:0] reg_read(input logic [7:0] a);
    logic [DATA_W-1:0] r;
    r = '0;
    if (addr_valid(a)) begin
      if (a == ADDR_STATUS)   r = status_in;
      else if (a == ADDR_CMD) r = cmd_code;
      else                    r = regs[a[3:0]];
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STORE; i++) regs[i] <= '0;
    end else if (acc_en && acc_wr && store_hit) begin
      regs[acc_addr[3:0]] <= acc_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_in    <= '0;
      app_ack   <= 1'b0;
      app_rdata <= '0;
      cmd_stb   <= 1'b0;
      cmd_code  <= '0;
    end else begin
      app_ack <= (state == ST_APP);
      cmd_stb <= 1'b0;
      if (state == ST_HOST && pend_rd) bus_in <= reg_read(pend_addr);
      if (state == ST_APP) app_rdata <= reg_read(app_addr);
      if (acc_en && acc_wr && acc_addr == ADDR_CMD) begin
        cmd_stb  <= 1'b1;
        cmd_code <= acc_wdata;
      end
    end
  end

  assign cfg0 = regs[ADDR_CFG0[3:0]];
  assign cfg1 = regs[ADDR_CFG1[3:0]];

endmodule

// File: tb/tb_epp_reg_arbiter.sv
// Directed bench for epp_reg_arbiter: host strobes, app requests, arbitration order,
// command pulses, address decode and strobe-held-through-reset behaviour.
module tb_epp_reg_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stb_data;
  logic       ctrl_wr;
  logic [7:0] bus_addr;
  logic [7:0] bus_out;
  logic [7:0] bus_in;
  logic       app_req;
  logic       app_wr;
  logic [7:0] app_addr;
  logic [7:0] app_wdata;
  logic       app_ack;
  logic [7:0] app_rdata;
  logic [7:0] status_in;
  logic [7:0] cfg0;
  logic [7:0] cfg1;
  logic       cmd_stb;
  logic [7:0] cmd_code;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  epp_reg_arbiter #(.CLK_MIN_MHZ(25)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .stb_data  (stb_data),
    .ctrl_wr   (ctrl_wr),
    .bus_addr  (bus_addr),
    .bus_out   (bus_out),
    .bus_in    (bus_in),
    .app_req   (app_req),
    .app_wr    (app_wr),
    .app_addr  (app_addr),
    .app_wdata (app_wdata),
    .app_ack   (app_ack),
    .app_rdata (app_rdata),
    .status_in (status_in),
    .cfg0      (cfg0),
    .cfg1      (cfg1),
    .cmd_stb   (cmd_stb),
    .cmd_code  (cmd_code)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic host_start(input logic rd, input logic [7:0] a, input logic [7:0] d);
    ctrl_wr  = rd;
    bus_addr = a;
    bus_out  = d;
    stb_data = 1'b0;
  endtask

  task automatic host_end();
    stb_data = 1'b1;
    tick(4);
  endtask

  task automatic app_start(input logic wr, input logic [7:0] a, input logic [7:0] d);
    app_wr    = wr;
    app_addr  = a;
    app_wdata = d;
    app_req   = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    stb_data  = 1'b1;
    ctrl_wr   = 1'b1;
    bus_addr  = 8'h00;
    bus_out   = 8'h00;
    app_req   = 1'b0;
    app_wr    = 1'b0;
    app_addr  = 8'h00;
    app_wdata = 8'h00;
    status_in = 8'hC3;
    tick(3);
    chk("rst_bus_in",    bus_in,              8'h00);
    chk("rst_app_ack",   {7'd0, app_ack},     8'h00);
    chk("rst_app_rdata", app_rdata,           8'h00);
    chk("rst_cfg0",      cfg0,                8'h00);
    chk("rst_cfg1",      cfg1,                8'h00);
    chk("rst_cmd_stb",   {7'd0, cmd_stb},     8'h00);
    chk("rst_cmd_code",  cmd_code,            8'h00);
    rst_n = 1'b1;
    tick(5);

    // Host write 0x5A->0x01 and app write 0x11->0x02 pending together: host first
    host_start(1'b0, 8'h01, 8'h5A);
    tick(3);
    app_start(1'b1, 8'h02, 8'h11);
    tick(2);
    chk("p1_cfg1",      cfg1,            8'h5A);
    chk("p1_cfg0_keep", cfg0,            8'h00);
    chk("p1_ack_e5",    {7'd0, app_ack}, 8'h00);
    tick(1);
    chk("p1_ack_e6",    {7'd0, app_ack}, 8'h00);
    tick(1);
    chk("p1_ack_e7",    {7'd0, app_ack}, 8'h01);
    app_req = 1'b0;
    tick(1);
    chk("p1_ack_pulse", {7'd0, app_ack}, 8'h00);
    host_end();

    // Last grant APP: host read 0x02 wins, then app read 0x01; held app_req re-grants
    host_start(1'b1, 8'h02, 8'h00);
    tick(3);
    app_start(1'b0, 8'h01, 8'h00);
    tick(2);
    chk("p2_bus_in",   bus_in,          8'h11);
    chk("p2_ack_e5",   {7'd0, app_ack}, 8'h00);
    tick(2);
    chk("p2_ack_e7",   {7'd0, app_ack}, 8'h01);
    chk("p2_rdata",    app_rdata,       8'h5A);
    tick(1);
    chk("p2_ack_e8",   {7'd0, app_ack}, 8'h00);
    tick(1);
    chk("p2_ack_e9",   {7'd0, app_ack}, 8'h00);
    tick(1);
    chk("p2_reack",    {7'd0, app_ack}, 8'h01);
    app_req = 1'b0;
    host_end();

    // Host-only write makes last grant HOST
    host_start(1'b0, 8'h00, 8'h44);
    tick(5);
    chk("p3_cfg0", cfg0, 8'h44);
    host_end();

    // Last grant HOST: app write 0x7E->0x0F wins over host read of 0x00
    host_start(1'b1, 8'h00, 8'h00);
    tick(3);
    app_start(1'b1, 8'h0F, 8'h7E);
    tick(2);
    chk("p4_ack",      {7'd0, app_ack}, 8'h01);
    chk("p4_cmd_stb",  {7'd0, cmd_stb}, 8'h01);
    chk("p4_cmd_code", cmd_code,        8'h7E);
    chk("p4_bus_hold", bus_in,          8'h11);
    app_req = 1'b0;
    tick(1);
    chk("p4_stb_off",  {7'd0, cmd_stb}, 8'h00);
    chk("p4_bus_e6",   bus_in,          8'h11);
    tick(1);
    chk("p4_bus_in",   bus_in,          8'h44);
    host_end();

    // Repeated identical command write pulses again
    app_start(1'b1, 8'h0F, 8'h7E);
    tick(2);
    chk("cmd2_ack",  {7'd0, app_ack}, 8'h01);
    chk("cmd2_stb",  {7'd0, cmd_stb}, 8'h01);
    app_req = 1'b0;
    tick(1);
    chk("cmd2_off",  {7'd0, cmd_stb}, 8'h00);
    chk("cmd2_code", cmd_code,        8'h7E);
    tick(2);

    // Status read within 5 cycles, held after strobe rises
    host_start(1'b1, 8'h0E, 8'h00);
    tick(5);
    chk("status_rd", bus_in, 8'hC3);
    stb_data  = 1'b1;
    status_in = 8'h00;
    tick(4);
    chk("status_hold", bus_in, 8'hC3);

    // Out-of-map addresses: read as zero, writes ignored
    host_start(1'b1, 8'h20, 8'h00);
    tick(5);
    chk("rd_0x20", bus_in, 8'h00);
    host_end();
    host_start(1'b0, 8'h10, 8'hFF);
    tick(5);
    chk("wr_0x10_cfg0", cfg0, 8'h44);
    host_end();
    host_start(1'b0, 8'h31, 8'hFF);
    tick(5);
    chk("wr_0x31_cfg1", cfg1, 8'h5A);
    host_end();

    // Strobe held low across reset must not produce an access
    host_start(1'b0, 8'h01, 8'h99);
    tick(1);
    rst_n = 1'b0;
    tick(2);
    chk("mid_rst_cfg1", cfg1,     8'h00);
    chk("mid_rst_cmd",  cmd_code, 8'h00);
    chk("mid_rst_bus",  bus_in,   8'h00);
    rst_n = 1'b1;
    tick(8);
    chk("held_cfg1",    cfg1,            8'h00);
    chk("held_ack",     {7'd0, app_ack}, 8'h00);
    host_end();
    host_start(1'b0, 8'h01, 8'h66);
    tick(5);
    chk("post_rst_cfg1", cfg1, 8'h66);
    host_end();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/epp_reg_arbiter.md
EPP_REG_ARBITER -- requirements
Module: epp_reg_arbiter

Interface
REQ-001 SHALL have parameter CLK_MIN_MHZ, default 25: documented minimum clk frequency for EPP timing closure; no functional effect.
REQ-002 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 stb_data  in  1  EPP data strobe, active-low, asynchronous to clk.
REQ-005 ctrl_wr  in  1  EPP write control, asynchronous; 0 = host write, 1 = host read.
REQ-006 bus_addr  in  8  latched EPP address; stable for the whole strobe.
REQ-007 bus_out  in  8  host write data; stable for the whole strobe.
REQ-008 bus_in  out  8  host read data, registered.
REQ-009 app_req  in  1  application access request, level, held until app_ack.
REQ-010 app_wr  in  1  application access type; 1 = write.
REQ-011 app_addr  in  8  application register address.
REQ-012 app_wdata  in  8  application write data.
REQ-013 app_ack  out  1  one-cycle pulse: application access done.
REQ-014 app_rdata  out  8  application read data, valid with app_ack.
REQ-015 status_in  in  8  read-only status, sampled at read.
REQ-016 cfg0, cfg1  out  8 each  contents of registers 0x00 and 0x01.
REQ-017 cmd_stb  out  1  one-cycle pulse on any write to 0x0F.
REQ-018 cmd_code  out  8  last value written to 0x0F.

Function
REQ-019 stb_data and ctrl_wr SHALL each pass through a 2-flop synchronizer before use.
REQ-020 A host request SHALL be raised on each falling edge of synchronized stb_data, but only while armed.
REQ-021 At the edge the block SHALL capture bus_addr, bus_out and synchronized ctrl_wr into a pending slot.
REQ-022 Register map: 0x00-0x0D read/write storage; 0x0E read-only status_in (writes ignored); 0x0F command register.
REQ-023 Any address with addr[7:4] != 0 SHALL be ignored on write and read as 0x00.
REQ-024 Arbiter FSM states SHALL be IDLE, HOST and APP; each access state SHALL last exactly one cycle, then return to IDLE.
REQ-025 From IDLE with both host pending and app_req: HOST SHALL be chosen if the last grant was APP; otherwise APP is chosen. After reset, the last grant counts as APP.
REQ-026 From IDLE with a single requester, that requester SHALL be granted.
REQ-027 A host request arriving during APP SHALL wait in the pending slot; nothing is lost.
REQ-028 In HOST, a write SHALL update the register array at the end of that cycle, and the pending slot SHALL clear.
REQ-029 In HOST, a read SHALL load bus_in on the next edge.
REQ-030 Host read latency from the stb_data fall SHALL be at most 5 clk cycles.
REQ-031 bus_in SHALL hold its value until the next host read.
REQ-032 In APP, the access SHALL be performed, and app_ack with app_rdata SHALL be registered one cycle later.
REQ-033 app_req still high after app_ack SHALL be treated as a new request.
REQ-034 A write to 0x0F SHALL update cmd_code and pulse cmd_stb for one cycle.
REQ-035 cmd_stb SHALL pulse again on a repeated identical write.
REQ-036 A second host edge while the pending slot is full is a protocol violation: the newer request SHALL overwrite the slot.

Reset
REQ-037 While rst_n is low, the following SHALL be 0: the register array, bus_in, app_ack, app_rdata, cmd_stb, cmd_code and the pending slot.
REQ-038 While rst_n is low, the FSM SHALL be IDLE and the synchronizer flops SHALL be 1.
REQ-039 The armed flag SHALL reset to 0 and set only after synchronized stb_data is seen high, so a strobe already low at reset release is ignored.
REQ-040 Reset asserted mid-access SHALL abandon the access with no partial register update.

Structure
REQ-041 Register addresses 0x00, 0x01, 0x0E, 0x0F, the FSM state encoding and the address-valid mask SHALL live in shared package epp_pkg.
REQ-042 The synchronizer plus falling-edge detector SHALL be sub-module epp_sync_edge, instantiated once per strobe; everything else stays in one module.

Verification
REQ-043 Host write 0x5A to 0x01 -> cfg1 = 0x5A within 5 cycles of the stb fall; the other registers stay unchanged.
REQ-044 Host read of 0x0E with status_in = 0xC3 -> bus_in = 0xC3 within 5 cycles, and held after the strobe rises.
REQ-045 Host write and app_req (write 0x11 to 0x02) pending in the same cycle, just after reset -> HOST served first, app_ack one grant later; back-to-back requests alternate.
REQ-046 App write 0x7E to 0x0F twice -> two cmd_stb pulses, cmd_code = 0x7E; host read of 0x20 -> bus_in = 0x00.
REQ-047 Hold stb_data low, pulse rst_n, release -> no access; the next full strobe is served normally.
